// File: rtl/aa_stream_filter.sv
// Raster-order 3x3 edge-softening filter (two line buffers); AA_DIAG_EN selects the 8-neighbour variant.
// Output for pixel k registers with accept of pixel k+IMG_W+1; any output stall freezes input and window.
module aa_stream_filter #(
   parameter int PIX_W = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PIX_W-1:0] th,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_data,
   input  logic             in_sof,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_data,
   output logic             out_sof,
   output logic             out_eol,
   output logic             done
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
`ifdef AA_DIAG_EN
   localparam int ACC_W = PIX_W + 4;
`else
   localparam int ACC_W = PIX_W + 3;
`endif

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;
   state_t state_q, state_d;

   logic [CW-1:0]    in_col_q, in_col_d, o_col_q, o_col_d, wr_col;
   logic [RW-1:0]    in_row_q, in_row_d, o_row_q, o_row_d;
   logic [PIX_W-1:0] th_q, th_d;
   logic [PIX_W-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d;
   logic             out_eol_q, out_eol_d, out_last_q, out_last_d, done_q, done_d;

   logic [PIX_W-1:0]           lb_a_q [IMG_W];
   logic [PIX_W-1:0]           lb_b_q [IMG_W];
   logic [2:0][2:0][PIX_W-1:0] win_q, win_d;

   logic             accept, restart, shift_in, drain_step, load, is_edge, border;
   logic [PIX_W-1:0] ctr, filt;
   logic [ACC_W-1:0] acc;

   assign in_ready   = !reset && (state_q != S_DRAIN) && (!out_valid_q || out_ready);
   assign accept     = in_valid && in_ready;
   assign restart    = accept && in_sof;
   assign shift_in   = accept && !in_sof && (state_q == S_FILL || state_q == S_RUN);
   assign drain_step = (state_q == S_DRAIN) && !out_last_q && (!out_valid_q || out_ready);
   assign load       = (shift_in && state_q == S_RUN) || drain_step;
   assign wr_col     = restart ? '0 : in_col_q;
   assign border     = (o_row_q == '0) || (o_row_q == RW'(IMG_H - 1)) ||
                       (o_col_q == '0) || (o_col_q == CW'(IMG_W - 1));

   // Next window: shift left, new right column = {row-2, row-1, current}; centre lands at [1][1].
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_d[r][0] = win_q[r][1];
         win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb_b_q[wr_col];
      win_d[1][2] = lb_a_q[wr_col];
      win_d[2][2] = (state_q == S_DRAIN) ? '0 : in_data;
   end

   always_comb begin
      ctr = win_d[1][1];
`ifdef AA_DIAG_EN
      acc     = ACC_W'(ctr) << 3;
      is_edge = 1'b0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (r != 1 || c != 1) begin
               acc = acc + ACC_W'(win_d[r][c]);
               if (win_d[r][c] < th_q) is_edge = 1'b1;
            end
         end
      end
      filt = PIX_W'(acc >> 4);
`else
      acc = (ACC_W'(ctr) << 2) + ACC_W'(win_d[0][1]) + ACC_W'(win_d[2][1]) +
            ACC_W'(win_d[1][0]) + ACC_W'(win_d[1][2]);
      is_edge = (win_d[0][1] < th_q) || (win_d[2][1] < th_q) ||
                (win_d[1][0] < th_q) || (win_d[1][2] < th_q);
      filt = PIX_W'(acc >> 3);
`endif
      is_edge = is_edge && (ctr > th_q);
   end

   always_comb begin
      state_d     = state_q;
      in_col_d    = in_col_q;
      in_row_d    = in_row_q;
      o_col_d     = o_col_q;
      o_row_d     = o_row_q;
      th_d        = th_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_sof_d   = out_sof_q;
      out_eol_d   = out_eol_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      if (restart) begin
         // A sof pixel always restarts the frame, discarding whatever was in flight.
         state_d     = S_FILL;
         th_d        = th;
         in_col_d    = CW'(1);
         in_row_d    = '0;
         o_col_d     = '0;
         o_row_d     = '0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else begin
         if (shift_in || drain_step) begin
            if (in_col_q == CW'(IMG_W - 1)) begin
               in_col_d = '0;
               in_row_d = (in_row_q == RW'(IMG_H - 1)) ? '0 : in_row_q + RW'(1);
            end else begin
               in_col_d = in_col_q + CW'(1);
            end
         end
         if (shift_in && state_q == S_FILL && in_row_q == RW'(1) && in_col_q == '0)
            state_d = S_RUN;
         if (shift_in && state_q == S_RUN && in_row_q == RW'(IMG_H - 1) && in_col_q == CW'(IMG_W - 1))
            state_d = S_DRAIN;
         if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = (border || !is_edge) ? ctr : filt;
            out_sof_d   = (o_row_q == '0) && (o_col_q == '0);
            out_eol_d   = (o_col_q == CW'(IMG_W - 1));
            out_last_d  = (o_row_q == RW'(IMG_H - 1)) && (o_col_q == CW'(IMG_W - 1));
            if (o_col_q == CW'(IMG_W - 1)) begin
               o_col_d = '0;
               o_row_d = (o_row_q == RW'(IMG_H - 1)) ? '0 : o_row_q + RW'(1);
            end else begin
               o_col_d = o_col_q + CW'(1);
            end
         end else if (out_ready) begin
            out_valid_d = 1'b0;
         end
         if (state_q == S_DRAIN && out_valid_q && out_ready && out_last_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         in_col_q    <= '0;
         in_row_q    <= '0;
         o_col_q     <= '0;
         o_row_q     <= '0;
         th_q        <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_eol_q   <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_col_q    <= in_col_d;
         in_row_q    <= in_row_d;
         o_col_q     <= o_col_d;
         o_row_q     <= o_row_d;
         th_q        <= th_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_eol_q   <= out_eol_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (restart || shift_in) begin
         lb_b_q[wr_col] <= lb_a_q[wr_col];
         lb_a_q[wr_col] <= in_data;
      end
      if (restart || shift_in || drain_step) win_q <= win_d;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sof   = out_sof_q;
   assign out_eol   = out_eol_q;
   assign done      = done_q;
endmodule

// File: tb/tb_aa_stream_filter.sv
// Directed bench for aa_stream_filter on a 4x4 frame, 8-bit pixels, threshold 100.
module tb_aa_stream_filter;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] th = 8'd100;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'd0;
   logic       in_sof = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic       out_sof;
   logic       out_eol;
   logic       done;

   int errors = 0;
   int checks = 0;

   logic [7:0] in_pix [32];
   bit         in_sofv [32];
   logic [7:0] exp_pix [16];
   logic [7:0] cap_d [$];
   bit         cap_s [$];
   bit         cap_e [$];
   int         done_cnt;

   aa_stream_filter #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) dut (
      .clk(clk), .reset(reset), .th(th),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sof(out_sof), .out_eol(out_eol), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic clear_frame();
      for (int i = 0; i < 32; i++) begin
         in_pix[i]  = 8'd0;
         in_sofv[i] = 1'b0;
      end
      for (int i = 0; i < 16; i++) exp_pix[i] = 8'd0;
      in_sofv[0] = 1'b1;
   endtask

   // Drive n pixels and collect delivered beats; all driving and sampling at negedge.
   task automatic run(input int n, input bit toggle, input bit abort_feed, input logic [7:0] th_after);
      int idx = 0;
      int cyc = 0;
      int tail = -1;
      bit rdy = 1'b1;
      bit held = 1'b0;
      bit drop_pend = 1'b0;
      logic [7:0] hd = 8'd0;
      logic hs = 1'b0;
      logic he = 1'b0;
      cap_d.delete();
      cap_s.delete();
      cap_e.delete();
      done_cnt = 0;
      while (1) begin
         @(negedge clk);
         if (done) done_cnt++;
         if (held) begin
            chk("stall valid", out_valid, 1);
            chk("stall data", out_data, hd);
            chk("stall sof", out_sof, hs);
            chk("stall eol", out_eol, he);
         end
         if (drop_pend) begin
            chk("resync drop", out_valid, 0);
            drop_pend = 1'b0;
         end
         if (idx >= 1) th = th_after;
         if (idx < n) begin
            in_valid = 1'b1;
            in_data  = in_pix[idx];
            in_sof   = in_sofv[idx];
         end else begin
            in_valid = 1'b0;
            in_sof   = 1'b0;
         end
         out_ready = toggle ? rdy : 1'b1;
         rdy = !rdy;
         #1;
         held = out_valid && !out_ready;
         hd = out_data;
         hs = out_sof;
         he = out_eol;
         if (out_valid && out_ready) begin
            cap_d.push_back(out_data);
            cap_s.push_back(out_sof);
            cap_e.push_back(out_eol);
         end
         if (in_valid && in_ready) begin
            if (in_sof && idx > 0) begin
               cap_d.delete();
               cap_s.delete();
               cap_e.delete();
               drop_pend = 1'b1;
            end
            idx++;
         end
         @(posedge clk);
         cyc++;
         if (abort_feed && idx == n) return;
         if (done_cnt > 0 && tail < 0) tail = 3;
         if (tail == 0) return;
         if (tail > 0) tail--;
         if (cyc >= 300) begin
            chk("timeout", cyc, 0);
            return;
         end
      end
   endtask

   task automatic cmp(input string tag);
      chk({tag, " count"}, cap_d.size(), 16);
      chk({tag, " done"}, done_cnt, 1);
      for (int i = 0; i < 16 && i < cap_d.size(); i++) begin
         chk($sformatf("%s data[%0d]", tag, i), cap_d[i], exp_pix[i]);
         chk($sformatf("%s sof[%0d]", tag, i), cap_s[i], (i == 0));
         chk($sformatf("%s eol[%0d]", tag, i), cap_e[i], (i % 4) == 3);
      end
   endtask

   task automatic load_frame_d();
      clear_frame();
      in_pix[6]  = 8'd10;
      in_pix[9]  = 8'd30;
      in_pix[10] = 8'd255;
      in_pix[11] = 8'd99;
      in_pix[14] = 8'd20;
      for (int i = 0; i < 16; i++) exp_pix[i] = in_pix[i];
      exp_pix[10] = 8'd147;
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      #1;
      chk("reset in_ready", in_ready, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_data", out_data, 0);
      chk("reset out_sof", out_sof, 0);
      chk("reset out_eol", out_eol, 0);
      chk("reset done", done, 0);
      reset = 1'b0;
      #1;
      chk("idle in_ready", in_ready, 1);

      // Flat frame
      clear_frame();
      for (int i = 0; i < 16; i++) begin
         in_pix[i]  = 8'd50;
         exp_pix[i] = 8'd50;
      end
      run(16, 1'b0, 1'b0, 8'd100);
      cmp("flat");

      // Single bright interior pixel
      clear_frame();
      in_pix[5]  = 8'd200;
      exp_pix[5] = 8'd100;
      run(16, 1'b0, 1'b0, 8'd100);
      cmp("spot11");

      // Bright corner passes through
      clear_frame();
      in_pix[0]  = 8'd200;
      exp_pix[0] = 8'd200;
      run(16, 1'b0, 1'b0, 8'd100);
      cmp("corner");

      // Truncating average; th changed after sof must not matter
      load_frame_d();
      run(16, 1'b0, 1'b0, 8'd0);
      cmp("trunc");
      th = 8'd100;

      // Strict comparisons: values equal to th neither trigger nor qualify
      clear_frame();
      in_pix[5] = 8'd200;
      in_pix[1] = 8'd100;
      in_pix[9] = 8'd100;
      in_pix[4] = 8'd100;
      in_pix[6] = 8'd100;
      for (int i = 0; i < 16; i++) exp_pix[i] = in_pix[i];
      run(16, 1'b0, 1'b0, 8'd100);
      cmp("strict");

      // Output backpressure, toggling ready
      load_frame_d();
      run(16, 1'b1, 1'b0, 8'd100);
      cmp("stall");

      // Resync on the 8th accepted pixel
      clear_frame();
      for (int i = 0; i < 7; i++) in_pix[i] = 8'd200;
      for (int i = 7; i < 23; i++) in_pix[i] = 8'd50;
      for (int i = 0; i < 16; i++) exp_pix[i] = 8'd50;
      in_sofv[7] = 1'b1;
      run(23, 1'b0, 1'b0, 8'd100);
      cmp("resync");

      // Reset during drain, then a clean frame
      clear_frame();
      for (int i = 0; i < 16; i++) in_pix[i] = 8'd50;
      run(16, 1'b0, 1'b1, 8'd100);
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      in_sof = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("drain reset in_ready", in_ready, 0);
      @(negedge clk);
      chk("drain reset out_valid", out_valid, 0);
      chk("drain reset done", done, 0);
      reset = 1'b0;
      #1;
      chk("post reset in_ready", in_ready, 1);
      clear_frame();
      in_pix[5]  = 8'd200;
      exp_pix[5] = 8'd100;
      run(16, 1'b0, 1'b0, 8'd100);
      cmp("after reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
